decode_pipe_stage: RTL and testbench
====================================

# decode_pipe_stage

Parametrised, pipelined MIPS instruction-decode stage. It accepts a fetched instruction and its PC+4 over a valid/ready handshake. It reads an internal register file, forms the immediate and jump target, and holds the result in an ID/EX pipeline register for the execute stage. It also detects load-use hazards, inserting a one-cycle bubble for each, and accepts write-back from the final stage.

## Interface
- DATA_W, 32, datapath width; legal values are 32 or 64.
- REG_AW, 5, register address width; the register file has 2^REG_AW entries.

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  stage accepts this cycle
- instr  input  32  instruction word
- pc_4  input  DATA_W  PC+4 of instr
- flush  input  1  discard held and incoming instruction (branch/jump taken)
- wb_en  input  1  write-back strobe
- wb_addr  input  REG_AW  write-back register
- wb_data  input  DATA_W  write-back value
- out_valid  output  1  ID/EX register holds a valid instruction
- out_ready  input  1  execute accepts
- out_opcode  output  6  instr[31:26]
- out_funct  output  6  instr[5:0]
- out_rs, out_rt, out_rd  output  REG_AW  register fields, zero-extended or truncated to REG_AW
- out_shamt  output  5  instr[10:6]
- out_a, out_b  output  DATA_W  operands read from rs and rt
- out_imm  output  DATA_W  extended immediate
- out_jump_addr  output  DATA_W  {pc_4[DATA_W-1:28], instr[25:0], 2'b00}
- out_pc_4  output  DATA_W  registered pc_4

## Operation
- **Register file**
  - Entry 0 always reads 0.
  - On the rising edge with wb_en=1 and wb_addr≠0, the entry is written with wb_data.
  - Reset clears every entry.
- **Accept condition:** accept = in_valid & in_ready.
  - in_ready = !reset & !flush & !stall & (!out_valid | out_ready).
- **On accept:** every out_* field is loaded from instr, pc_4 and the register-file reads, and out_valid is set to 1.
- **Handshake:** on out_valid & out_ready with no accept in the same cycle, out_valid is set to 0.
- **Hold refresh:** while out_valid=1 and out_ready=0, a write-back with wb_addr≠0 matching out_rs or out_rt replaces out_a or out_b with wb_data.
- **Immediate forms**
  - Opcodes 0x0C, 0x0D, 0x0E (andi/ori/xori): zero-extend instr[15:0].
  - Opcode 0x0F (lui): {instr[15:0], 16'b0}, sign-extended to DATA_W.
  - All other opcodes: sign-extend instr[15:0].
- **Load-use hazard**
  - When an instruction with opcode 0x23 (lw) transfers downstream, load_dest=rt and load_pend=1 are recorded, provided rt≠0.
  - stall=1 when load_pend=1 and in_valid=1 and instr rs or rt equals load_dest.
  - rt counts as a source only for R-type (opcode 0), beq/bne (0x04/0x05) and sw (0x2B).
  - load_pend clears after one cycle in which no load transfers, regardless of whether a stall occurred.
  - Net effect: exactly one bubble per dependent instruction.
- **flush:** sets out_valid=0, clears load_pend and drops the incoming instruction. flush takes priority over accept and over refresh.

## Timing
- Latency is one cycle: an instruction accepted at edge N appears with out_valid=1 after edge N.
- Throughput is one instruction per cycle when out_ready=1 and there is no hazard.
- in_ready is combinational from out_ready, flush, in_valid and instr; there is no combinational path from in_valid to out_valid.
- Reset, asynchronous:
  - out_valid=0, load_pend=0.
  - All out_* data outputs are 0.
  - All registers are 0.
  - in_ready=0 while reset is high.
- Reset mid-transfer drops the held instruction. The first accept is possible on the first edge after deassertion.
- Simultaneous out_ready=1 and accept: the held instruction transfers and the new one loads on the same edge.
- Simultaneous write-back and read of the same register: see Configuration.
- Write-back to register 0 is ignored in every path: register file, bypass and refresh.

## Configuration
- DECODE_BYPASS_EN defined: on accept, if wb_en=1 and wb_addr≠0 equals rs (or rt), out_a (or out_b) captures wb_data in that cycle (write-first).
- DECODE_BYPASS_EN undefined: out_a and out_b capture the pre-write register content (read-first).
  - Software or the hazard unit must provide one separating cycle.
  - Hold refresh remains active.

## Test plan
- Reset, then write r5=0x1234 via wb, then accept add r3,r5,r0 (0x00A01820) → next cycle out_valid=1, out_a=0x1234, out_b=0, out_rd=3.
- Accept addi with imm 0xFFFE → out_imm=0xFFFFFFFE; accept ori with 0xFFFE → out_imm=0x0000FFFE; accept lui with 0x8000 → out_imm=0x80000000.
- lw r8 transfers, next instruction is add r9,r8,r8 → in_ready=0 for one cycle, out_valid=0 for one cycle, then accepted; an independent instruction after lw is not stalled.
- Accept with wb_en=1, wb_addr=rs=7, wb_data=0xCAFE: with DECODE_BYPASS_EN, out_a=0xCAFE; without it, out_a equals the old r7.
- Hold out_ready=0 for 3 cycles and write rt=4 with 0x55 during the hold → out_b becomes 0x55 before transfer; out_* fields are otherwise stable.
- Assert flush while out_valid=1 and in_valid=1 → next cycle out_valid=0, instruction not accepted; assert reset mid-hold → out_valid=0 immediately, all outputs 0.

Source files
------------

// File: rtl/decode_pipe_stage_if.sv
// Handshake and data bundle for the MIPS decode stage: fetch input, write-back
// port and the ID/EX register outputs.
interface decode_pipe_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) ();
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [DATA_W-1:0] pc_4;
    logic              flush;
    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        out_opcode;
    logic [5:0]        out_funct;
    logic [REG_AW-1:0] out_rs;
    logic [REG_AW-1:0] out_rt;
    logic [REG_AW-1:0] out_rd;
    logic [4:0]        out_shamt;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [DATA_W-1:0] out_imm;
    logic [DATA_W-1:0] out_jump_addr;
    logic [DATA_W-1:0] out_pc_4;

    // Fetch/write-back/execute side.
    modport master (
        output in_valid, instr, pc_4, flush, wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, out_opcode, out_funct, out_rs, out_rt, out_rd,
               out_shamt, out_a, out_b, out_imm, out_jump_addr, out_pc_4
    );

    // Decode stage side.
    modport slave (
        input  in_valid, instr, pc_4, flush, wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, out_opcode, out_funct, out_rs, out_rt, out_rd,
               out_shamt, out_a, out_b, out_imm, out_jump_addr, out_pc_4
    );
endinterface

// File: rtl/decode_pipe_stage.sv
// MIPS decode stage: register file, immediate/jump formation, ID/EX register and
// load-use stall. Define DECODE_BYPASS_EN for write-first operand capture.
module decode_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input logic               clk,
    input logic               reset,
    decode_pipe_stage_if.slave bus
);
    localparam int NREG = 1 << REG_AW;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [DATA_W-1:0] rf [NREG];

    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [DATA_W-1:0] rd_a, rd_b, imm, jump_addr;
    logic              wb_live, uses_rt, stall, accept, xfer, lw_xfer;
    logic              load_pend;
    logic [REG_AW-1:0] load_dest;

    assign opcode    = bus.instr[31:26];
    assign rs        = REG_AW'(bus.instr[25:21]);
    assign rt        = REG_AW'(bus.instr[20:16]);
    assign rd        = REG_AW'(bus.instr[15:11]);
    assign wb_live   = bus.wb_en && (bus.wb_addr != '0);
    assign jump_addr = {bus.pc_4[DATA_W-1:28], bus.instr[25:0], 2'b00};

`ifdef DECODE_BYPASS_EN
    assign rd_a = (rs == '0) ? '0 : (wb_live && bus.wb_addr == rs) ? bus.wb_data : rf[rs];
    assign rd_b = (rt == '0) ? '0 : (wb_live && bus.wb_addr == rt) ? bus.wb_data : rf[rt];
`else
    assign rd_a = (rs == '0) ? '0 : rf[rs];
    assign rd_b = (rt == '0) ? '0 : rf[rt];
`endif

    // NOTE: every path assigns imm (default arm included), so no latch is inferred.
    always_comb begin
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: imm = DATA_W'(bus.instr[15:0]);
            OP_LUI:  imm = {{(DATA_W-31){bus.instr[15]}}, bus.instr[14:0], 16'h0000};
            default: imm = {{(DATA_W-16){bus.instr[15]}}, bus.instr[15:0]};
        endcase
    end

    // rt is a destination for I-type ALU ops and loads, so it only stalls where it is read.
    assign uses_rt = opcode inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
    assign stall   = load_pend && bus.in_valid &&
                     ((rs == load_dest) || (uses_rt && rt == load_dest));

    assign bus.in_ready = !reset && !bus.flush && !stall && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign xfer         = bus.out_valid && bus.out_ready;
    assign lw_xfer      = xfer && (bus.out_opcode == OP_LW) && (bus.out_rt != '0);

    // NOTE: the register file is cleared on reset, so it is built from resettable flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wb_live) begin
            rf[bus.wb_addr] <= bus.wb_data;
        end
    end

    // NOTE: state updates use <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid     <= 1'b0;
            bus.out_opcode    <= '0;
            bus.out_funct     <= '0;
            bus.out_rs        <= '0;
            bus.out_rt        <= '0;
            bus.out_rd        <= '0;
            bus.out_shamt     <= '0;
            bus.out_a         <= '0;
            bus.out_b         <= '0;
            bus.out_imm       <= '0;
            bus.out_jump_addr <= '0;
            bus.out_pc_4      <= '0;
            load_pend         <= 1'b0;
            load_dest         <= '0;
        end else begin
            load_pend <= lw_xfer;
            if (lw_xfer) load_dest <= bus.out_rt;

            if (bus.flush) begin
                bus.out_valid <= 1'b0;
                load_pend     <= 1'b0;
            end else if (accept) begin
                bus.out_valid     <= 1'b1;
                bus.out_opcode    <= opcode;
                bus.out_funct     <= bus.instr[5:0];
                bus.out_rs        <= rs;
                bus.out_rt        <= rt;
                bus.out_rd        <= rd;
                bus.out_shamt     <= bus.instr[10:6];
                bus.out_a         <= rd_a;
                bus.out_b         <= rd_b;
                bus.out_imm       <= imm;
                bus.out_jump_addr <= jump_addr;
                bus.out_pc_4      <= bus.pc_4;
            end else if (xfer) begin
                bus.out_valid <= 1'b0;
            end else if (bus.out_valid) begin
                // Held instruction picks up late write-backs to its source registers.
                if (wb_live && bus.wb_addr == bus.out_rs) bus.out_a <= bus.wb_data;
                if (wb_live && bus.wb_addr == bus.out_rt) bus.out_b <= bus.wb_data;
            end
        end
    end
endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed bench for decode_pipe_stage with a scoreboard of expected ID/EX contents.
module tb_decode_pipe_stage;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
`ifdef DECODE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs, rt, rd, shamt;
        logic [31:0] a, b, imm, jaddr, pc4;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    exp_t sb[$];
    logic [31:0] rf_m [32];
    int checks = 0;
    int errors = 0;

    decode_pipe_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();
    decode_pipe_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs, rt, rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, rt,
                                           input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic logic [31:0] read_m(input logic [4:0] r, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (BYPASS && we && wa != 5'd0 && wa == r) return wd;
        return rf_m[r];
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc4, input logic we,
                                   input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        e.opcode = ins[31:26];
        e.funct  = ins[5:0];
        e.rs     = ins[25:21];
        e.rt     = ins[20:16];
        e.rd     = ins[15:11];
        e.shamt  = ins[10:6];
        e.a      = read_m(e.rs, we, wa, wd);
        e.b      = read_m(e.rt, we, wa, wd);
        if (e.opcode == 6'h0C || e.opcode == 6'h0D || e.opcode == 6'h0E)
            e.imm = {16'h0000, ins[15:0]};
        else if (e.opcode == 6'h0F)
            e.imm = {ins[15:0], 16'h0000};
        else
            e.imm = {{16{ins[15]}}, ins[15:0]};
        e.jaddr = {pc4[31:28], ins[25:0], 2'b00};
        e.pc4   = pc4;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.pc_4      = '0;
        bus.flush     = 1'b0;
        bus.wb_en     = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        bus.out_ready = 1'b1;
    endtask

    task automatic wb_write(input logic [4:0] wa, input logic [31:0] wd);
        bus.wb_en   = 1'b1;
        bus.wb_addr = wa;
        bus.wb_data = wd;
        step();
        bus.wb_en = 1'b0;
        if (wa != 5'd0) rf_m[wa] = wd;
    endtask

    task automatic accept_wb(input string tag, input logic [31:0] ins, input logic [31:0] pc4,
                             input logic we, input logic [4:0] wa, input logic [31:0] wd);
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        bus.pc_4     = pc4;
        bus.wb_en    = we;
        bus.wb_addr  = wa;
        bus.wb_data  = wd;
        #1;
        check($sformatf("%s_in_ready", tag), bus.in_ready, 1);
        sb.push_back(model(ins, pc4, we, wa, wd));
        if (we && wa != 5'd0) rf_m[wa] = wd;
        step();
        bus.in_valid = 1'b0;
        bus.wb_en    = 1'b0;
    endtask

    task automatic accept(input string tag, input logic [31:0] ins, input logic [31:0] pc4);
        accept_wb(tag, ins, pc4, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        check($sformatf("%s_sb_nonempty", tag), sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check($sformatf("%s_valid", tag),  bus.out_valid,     1);
            check($sformatf("%s_opcode", tag), bus.out_opcode,    e.opcode);
            check($sformatf("%s_funct", tag),  bus.out_funct,     e.funct);
            check($sformatf("%s_rs", tag),     bus.out_rs,        e.rs);
            check($sformatf("%s_rt", tag),     bus.out_rt,        e.rt);
            check($sformatf("%s_rd", tag),     bus.out_rd,        e.rd);
            check($sformatf("%s_shamt", tag),  bus.out_shamt,     e.shamt);
            check($sformatf("%s_a", tag),      bus.out_a,         e.a);
            check($sformatf("%s_b", tag),      bus.out_b,         e.b);
            check($sformatf("%s_imm", tag),    bus.out_imm,       e.imm);
            check($sformatf("%s_jaddr", tag),  bus.out_jump_addr, e.jaddr);
            check($sformatf("%s_pc4", tag),    bus.out_pc_4,      e.pc4);
        end
    endtask

    initial begin
        exp_t e;
        for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
        drive_idle();
        #2;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_a", bus.out_a, 0);
        check("rst_out_imm", bus.out_imm, 0);
        check("rst_out_pc_4", bus.out_pc_4, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        wb_write(5'd5, 32'h1234);
        wb_write(5'd6, 32'h0F0F);
        wb_write(5'd7, 32'h7777);
        wb_write(5'd4, 32'h1111);
        wb_write(5'd0, 32'hDEAD);

        // Basic R-type, then back-to-back immediates and a jump at full throughput.
        accept("add", 32'h00A01820, 32'h0040_0004);
        check("add_a_lit", bus.out_a, 32'h1234);
        check("add_rd_lit", bus.out_rd, 3);
        check_out("add");
        accept("addi", i_type(6'h08, 5'd5, 5'd1, 16'hFFFE), 32'h0040_0008);
        check("addi_imm_lit", bus.out_imm, 32'hFFFF_FFFE);
        check_out("addi");
        accept("ori", i_type(6'h0D, 5'd5, 5'd2, 16'hFFFE), 32'h0040_000C);
        check("ori_imm_lit", bus.out_imm, 32'h0000_FFFE);
        check_out("ori");
        accept("lui", i_type(6'h0F, 5'd0, 5'd3, 16'h8000), 32'h0040_0010);
        check("lui_imm_lit", bus.out_imm, 32'h8000_0000);
        check_out("lui");
        accept("jmp", 32'h0812_3456, 32'hA000_0010);
        check("jmp_jaddr_lit", bus.out_jump_addr, 32'hA048_D158);
        check_out("jmp");
        accept("r0", r_type(5'd0, 5'd0, 5'd1), 32'h0040_0018);
        check_out("r0");
        step();

        // Load-use: dependent add stalls one cycle after lw transfers.
        accept("lw1", i_type(6'h23, 5'd5, 5'd8, 16'h0000), 32'h0040_0020);
        check_out("lw1");
        step();
        bus.in_valid = 1'b1;
        bus.instr    = r_type(5'd8, 5'd8, 5'd9);
        #1;
        check("lu_stall_ready", bus.in_ready, 0);
        step();
        check("lu_bubble_valid", bus.out_valid, 0);
        accept("lu_add", r_type(5'd8, 5'd8, 5'd9), 32'h0040_0024);
        check_out("lu_add");
        step();

        // addi reads only rs; its rt matching the load is not a hazard.
        accept("lw2", i_type(6'h23, 5'd5, 5'd8, 16'h0004), 32'h0040_0028);
        check_out("lw2");
        step();
        accept("indep", i_type(6'h08, 5'd6, 5'd8, 16'h0001), 32'h0040_002C);
        check_out("indep");
        step();

        // beq reads rt, so it stalls.
        accept("lw3", i_type(6'h23, 5'd5, 5'd8, 16'h0008), 32'h0040_0030);
        check_out("lw3");
        step();
        bus.in_valid = 1'b1;
        bus.instr    = i_type(6'h04, 5'd0, 5'd8, 16'h0004);
        #1;
        check("beq_stall_ready", bus.in_ready, 0);
        step();
        accept("beq", i_type(6'h04, 5'd0, 5'd8, 16'h0004), 32'h0040_0034);
        check_out("beq");
        step();

        // Write-back to rs in the accept cycle.
        accept_wb("byp", r_type(5'd7, 5'd6, 5'd1), 32'h0040_0038, 1'b1, 5'd7, 32'hCAFE);
        check("byp_a_lit", bus.out_a, BYPASS ? 32'hCAFE : 32'h7777);
        check_out("byp");
        step();

        // Hold for three cycles with a write-back to rt in the middle.
        accept("hold", r_type(5'd5, 5'd4, 5'd2), 32'h0040_003C);
        bus.out_ready = 1'b0;
        #1;
        check("hold_in_ready", bus.in_ready, 0);
        check("hold_b_before", bus.out_b, 32'h1111);
        step();
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd4;
        bus.wb_data = 32'h55;
        step();
        bus.wb_en = 1'b0;
        rf_m[4] = 32'h55;
        check("hold_b_refresh", bus.out_b, 32'h55);
        check("hold_a_stable", bus.out_a, 32'h1234);
        check("hold_rd_stable", bus.out_rd, 2);
        step();
        e = sb.pop_front();
        e.b = 32'h55;
        sb.push_front(e);
        bus.out_ready = 1'b1;
        check_out("hold");
        step();

        // Flush with a held instruction and a new one offered.
        accept("pre_flush", r_type(5'd5, 5'd6, 5'd3), 32'h0040_0040);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr     = i_type(6'h08, 5'd5, 5'd1, 16'h0010);
        bus.flush     = 1'b1;
        #1;
        check("flush_in_ready", bus.in_ready, 0);
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_out_valid", bus.out_valid, 0);
        sb.delete();
        bus.out_ready = 1'b1;
        step();
        check("flush_dropped", bus.out_valid, 0);

        // Reset in the middle of a hold.
        accept("pre_rst", r_type(5'd5, 5'd6, 5'd3), 32'h0040_0044);
        bus.out_ready = 1'b0;
        #1;
        check("pre_rst_valid", bus.out_valid, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_a", bus.out_a, 0);
        check("mid_rst_b", bus.out_b, 0);
        check("mid_rst_imm", bus.out_imm, 0);
        check("mid_rst_jaddr", bus.out_jump_addr, 0);
        check("mid_rst_pc_4", bus.out_pc_4, 0);
        check("mid_rst_rd", bus.out_rd, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        sb.delete();
        for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
        step();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        accept("post_rst", 32'h00A01820, 32'h0040_0048);
        check("post_rst_a", bus.out_a, 0);
        check_out("post_rst");
        step();
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
